// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: systolic-array job sequencer (load weights/data, clear, start, wait, read back); define SA_SEQ_TIMEOUT_EN to enable the WAIT watchdog
module sa_seq_ctrl #(
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 255,
  parameter int MAC_W   = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              job_vi,
  output logic              job_ro,
  input  logic [MEM_AW-1:0] job_w_base_i,
  input  logic [MEM_AW-1:0] job_x_base_i,
  input  logic [MEM_AW-1:0] job_r_base_i,
  input  logic              job_skip_w_i,
  output logic [MEM_AW-1:0] mem_raddr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [7:0]        arr_addr_o,
  output logic [31:0]       arr_data_o,
  output logic              arr_wr_vo,
  input  logic [MAC_W-1:0]  arr_rdata_i,
  output logic [MEM_AW-1:0] res_waddr_o,
  output logic [MAC_W-1:0]  res_wdata_o,
  output logic              res_wr_vo,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT + 129);
  typedef enum logic [2:0] {IDLE, LD_W, LD_X, CLR, START, WAIT, RD, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MEM_AW-1:0] w_base_q, w_base_d, x_base_q, x_base_d, r_base_q, r_base_d;
`ifdef SA_SEQ_TIMEOUT_EN
  logic err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
  // State, phase counter and latched descriptor; reset forces IDLE at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      r_base_q <= '0;
`ifdef SA_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      r_base_q <= r_base_d;
`ifdef SA_SEQ_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end
  // Next state and outputs; loads write the word fetched the previous cycle, readback samples on the second cycle of each address
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    w_base_d    = w_base_q;
    x_base_d    = x_base_q;
    r_base_d    = r_base_q;
`ifdef SA_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif
    job_ro      = 1'b0;
    mem_raddr_o = '0;
    arr_addr_o  = '0;
    arr_data_o  = '0;
    arr_wr_vo   = 1'b0;
    res_waddr_o = '0;
    res_wdata_o = '0;
    res_wr_vo   = 1'b0;
    busy_o      = state_q != IDLE;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        job_ro = 1'b1;
        cnt_d  = '0;
        if (job_vi) begin
          w_base_d = job_w_base_i;
          x_base_d = job_x_base_i;
          r_base_d = job_r_base_i;
`ifdef SA_SEQ_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = job_skip_w_i ? LD_X : LD_W;
        end
      end
      LD_W, LD_X: begin
        mem_raddr_o = (state_q == LD_W ? w_base_q : x_base_q) + MEM_AW'(cnt_q[5:0]);
        arr_wr_vo   = cnt_q != '0;
        arr_addr_o  = {1'b0, state_q == LD_X, 6'(cnt_q - CW'(1))};
        arr_data_o  = arr_wr_vo ? mem_rdata_i : 32'd0;
        if (cnt_q == CW'(64)) begin
          cnt_d   = '0;
          state_d = state_q == LD_W ? LD_X : CLR;
        end
      end
      CLR: begin
        arr_addr_o = 8'd128;
        arr_wr_vo  = 1'b1;
        state_d    = START;
      end
      START: begin
        arr_addr_o = 8'd192;
        arr_data_o = 32'd1;
        arr_wr_vo  = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        arr_addr_o = 8'd192;
        if (cnt_q >= CW'(2) && arr_rdata_i[0]) begin
          cnt_d   = '0;
          state_d = RD;
        end
`ifdef SA_SEQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      RD: begin
        arr_addr_o  = {2'b10, cnt_q[6:1]};
        res_wr_vo   = cnt_q[0];
        res_waddr_o = res_wr_vo ? r_base_q + MEM_AW'(cnt_q[6:1]) : '0;
        res_wdata_o = res_wr_vo ? arr_rdata_i : '0;
        if (cnt_q == CW'(127)) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: randomized bench for sa_seq_ctrl with a source memory, an array model and a job-level reference
module tb_sa_seq_ctrl;
  localparam int MEM_AW = 10;
  localparam int TIMEOUT = 255;
  localparam int MAC_W = 19;
  localparam int NEVER = 1 << 30;
  logic              clk_i = 0, rst_i = 1;
  logic              job_vi = 0, job_ro, job_skip_w_i = 0;
  logic [MEM_AW-1:0] job_w_base_i = 0, job_x_base_i = 0, job_r_base_i = 0;
  logic [MEM_AW-1:0] mem_raddr_o, res_waddr_o;
  logic [31:0]       mem_rdata_i = 0, arr_data_o;
  logic [7:0]        arr_addr_o;
  logic              arr_wr_vo, res_wr_vo, busy_o, done_o, err_o;
  logic [MAC_W-1:0]  arr_rdata_i, res_wdata_o;
  logic [31:0]       src [1024];
  logic [31:0]       amem [256];
  logic [31:0]       wmodel [64];
  int                sc = 0, lat = 0, nwait = 0, ndone = 0;
  int                nchk = 0, npass = 0;
  logic [7:0]        aw_a [$];
  logic [31:0]       aw_d [$];
  int                rw_a [$];
  logic [31:0]       rw_d [$];

  sa_seq_ctrl #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT), .MAC_W(MAC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .job_vi(job_vi), .job_ro(job_ro),
    .job_w_base_i(job_w_base_i), .job_x_base_i(job_x_base_i), .job_r_base_i(job_r_base_i),
    .job_skip_w_i(job_skip_w_i), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .arr_addr_o(arr_addr_o), .arr_data_o(arr_data_o), .arr_wr_vo(arr_wr_vo), .arr_rdata_i(arr_rdata_i),
    .res_waddr_o(res_waddr_o), .res_wdata_o(res_wdata_o), .res_wr_vo(res_wr_vo),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Source memory with one-cycle read latency
  always @(posedge clk_i) mem_rdata_i <= src[mem_raddr_o];

  // Array model: stores writes, raises ready lat cycles into WAIT, returns weight+data sums on readback
  always @(posedge clk_i) begin
    if (arr_wr_vo) amem[arr_addr_o] <= arr_data_o;
    sc <= (arr_wr_vo && arr_addr_o == 8'd192) ? 0 : sc + 1;
  end
  always_comb begin
    arr_rdata_i = MAC_W'(amem[{2'b00, arr_addr_o[5:0]}] + amem[{2'b01, arr_addr_o[5:0]}]);
    if (arr_addr_o == 8'd192) arr_rdata_i = {{(MAC_W-1){1'b0}}, sc >= lat};
  end

  // Transaction monitor, sampled mid-cycle
  always @(negedge clk_i) if (!rst_i) begin
    if (arr_wr_vo) begin aw_a.push_back(arr_addr_o); aw_d.push_back(arr_data_o); end
    if (res_wr_vo) begin rw_a.push_back(int'(res_waddr_o)); rw_d.push_back(32'(res_wdata_o)); end
    if (done_o) ndone++;
    if (busy_o && arr_addr_o == 8'd192 && !arr_wr_vo) nwait++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    aw_a.delete(); aw_d.delete(); rw_a.delete(); rw_d.delete();
    nwait = 0; ndone = 0;
  endtask

  task automatic run_job(input int w, input int x, input int r, input bit skip, input int l, input bit hold, input bit to);
    logic [7:0]  ea [$];
    logic [31:0] ed [$];
    int t, base;
    clear_mon();
    lat = l;
    @(negedge clk_i);
    job_w_base_i = MEM_AW'(w); job_x_base_i = MEM_AW'(x); job_r_base_i = MEM_AW'(r);
    job_skip_w_i = skip; job_vi = 1;
    chk("job_ro_idle", 32'(job_ro), 1);
    @(posedge clk_i); #1;
    if (!hold) job_vi = 0;
    chk("err_clr_on_accept", 32'(err_o), 0);
    base = skip ? x : w;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      chk("raddr", 32'(mem_raddr_o), 32'((base + k) % 1024));
      if (k == 0) chk("busy_run", 32'(busy_o), 1);
    end
    t = 0;
    while (!done_o && t < 5000) begin @(negedge clk_i); t++; end
    chk("done_seen", 32'(done_o), 1);
    job_vi = 0;
    chk("err_at_done", 32'(err_o), 32'(to));
    repeat (4) @(negedge clk_i);
    chk("busy_after", 32'(busy_o), 0);
    chk("done_count", 32'(ndone), 1);
    if (!skip) for (int k = 0; k < 64; k++) begin
      wmodel[k] = src[(w + k) % 1024];
      ea.push_back(8'(k)); ed.push_back(wmodel[k]);
    end
    for (int k = 0; k < 64; k++) begin ea.push_back(8'(64 + k)); ed.push_back(src[(x + k) % 1024]); end
    ea.push_back(8'd128); ed.push_back(0);
    ea.push_back(8'd192); ed.push_back(0);
    chk("arr_wr_count", 32'(aw_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < aw_a.size(); i++) begin
      chk("arr_wr_addr", 32'(aw_a[i]), 32'(ea[i]));
      if (ea[i] != 8'd192) chk("arr_wr_data", aw_d[i], ed[i]);
    end
    if (to) begin
      chk("res_wr_count_to", 32'(rw_a.size()), 0);
      chk("wait_cycles_to", 32'(nwait), 32'(TIMEOUT));
    end else begin
      chk("res_wr_count", 32'(rw_a.size()), 64);
      chk("wait_cycles", 32'(nwait), 32'((l > 2 ? l : 2) + 1));
      for (int j = 0; j < 64 && j < rw_a.size(); j++) begin
        chk("res_addr", 32'(rw_a[j]), 32'((r + j) % 1024));
        chk("res_data", rw_d[j], 32'(MAC_W'(wmodel[j] + src[(x + j) % 1024])));
      end
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) src[i] = $urandom;
    for (int i = 0; i < 256; i++) amem[i] = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_job_ro", 32'(job_ro), 1);
    chk("rst_zero", 32'(|{mem_raddr_o, arr_addr_o, arr_data_o, arr_wr_vo, res_waddr_o, res_wdata_o, res_wr_vo, busy_o, done_o, err_o}), 0);
    rst_i = 0;
    run_job(0, 64, 512, 0, 24, 0, 0);
    run_job(0, 64, 512, 1, 24, 0, 0);
    run_job(1020, 100, 1000, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++)
      run_job($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)), $urandom_range(1, 40), 0, 0);
    run_job($urandom_range(0, 1023), $urandom_range(0, 1023), 300, 0, 5, 1, 0);
    clear_mon();
    lat = 10;
    @(negedge clk_i);
    job_w_base_i = 10; job_x_base_i = 200; job_r_base_i = 700; job_skip_w_i = 0; job_vi = 1;
    @(posedge clk_i); #1; job_vi = 0;
    t = 0;
    while (arr_addr_o != 8'd158 && t < 2000) begin @(negedge clk_i); t++; end
    chk("reach_rd_j30", 32'(arr_addr_o), 158);
    rst_i = 1; #1;
    chk("midrd_rst_job_ro", 32'(job_ro), 1);
    chk("midrd_rst_zero", 32'(|{mem_raddr_o, arr_addr_o, arr_data_o, arr_wr_vo, res_waddr_o, res_wdata_o, res_wr_vo, busy_o, done_o, err_o}), 0);
    @(negedge clk_i); rst_i = 0;
    run_job(5, 900, 100, 0, 24, 0, 0);
`ifdef SA_SEQ_TIMEOUT_EN
    run_job(33, 77, 400, 0, NEVER, 0, 1);
    run_job(33, 77, 400, 1, 3, 0, 0);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/sa_seq_ctrl.md
SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 SHALL have parameters: MEM_AW, default 10, source/result memory address width; TIMEOUT, default 255, watchdog limit in cycles; MAC_W, default 19, output word width.
REQ-002 SHALL have ports: clk_i  in  1  single clock, rising edge; rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: job_vi  in  1  job valid; job_ro  out  1  job ready; job_w_base_i  in  MEM_AW  weight base; job_x_base_i  in  MEM_AW  data base; job_r_base_i  in  MEM_AW  result base; job_skip_w_i  in  1  reuse loaded weights.
REQ-004 SHALL have ports: mem_raddr_o  out  MEM_AW  source read address; mem_rdata_i  in  32  source data, valid one cycle after address.
REQ-005 SHALL have ports: arr_addr_o  out  8  array address; arr_data_o  out  32  array write data; arr_wr_vo  out  1  array write strobe; arr_rdata_i  in  MAC_W  array read data.
REQ-006 SHALL have ports: res_waddr_o  out  MEM_AW; res_wdata_o  out  MAC_W; res_wr_vo  out  1  result write strobe; busy_o  out  1; done_o  out  1  one-cycle job-complete pulse; err_o  out  1  sticky timeout flag.

Function
REQ-007 SHALL implement states IDLE, LD_W, LD_X, CLR, START, WAIT, RD, DONE.
REQ-008 SHALL assert job_ro only in IDLE; job accepted on job_vi&&job_ro; descriptor fields latched on acceptance; err_o cleared on acceptance.
REQ-009 SHALL go IDLE->LD_W on acceptance, or IDLE->LD_X when job_skip_w_i=1.
REQ-010 LD_W SHALL issue mem_raddr_o=w_base+k for k=0..63 on consecutive cycles and write mem_rdata_i to arr_addr_o=k one cycle later; phase lasts 65 cycles, then LD_X.
REQ-011 LD_X SHALL do the same from x_base to array addresses 64+k, 65 cycles, then CLR.
REQ-012 CLR SHALL issue one write to arr_addr_o=128 with arr_data_o=0, then START.
REQ-013 START SHALL issue one write to arr_addr_o=192, then WAIT.
REQ-014 WAIT SHALL hold arr_addr_o=192, arr_wr_vo=0, ignore arr_rdata_i[0] for the first 2 cycles, then go RD on the first cycle arr_rdata_i[0]=1.
REQ-015 RD SHALL read outputs j=0..63 at arr_addr_o=128+j, holding each address 2 cycles and sampling arr_rdata_i on the second; on that cycle res_wr_vo=1, res_waddr_o=r_base+j, res_wdata_o=sample; 128 cycles, then DONE.
REQ-016 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-017 Memory address arithmetic SHALL wrap modulo 2^MEM_AW.
REQ-018 arr_wr_vo and res_wr_vo SHALL never assert outside the cycles defined above; busy_o=1 in every state except IDLE.
REQ-019 job_vi asserted while busy SHALL be ignored; no queueing.

Reset
REQ-020 rst_i=1 SHALL immediately force IDLE and all outputs to 0 except job_ro=1, at any state including mid-load or mid-readback.
REQ-021 Partial array contents after reset mid-job are undefined; next job SHALL restart from its first phase.

Configuration
REQ-022 With SA_SEQ_TIMEOUT_EN defined, WAIT SHALL count cycles and after TIMEOUT cycles without ready set err_o=1, skip RD, go DONE (done_o still pulses).
REQ-023 Without SA_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_o SHALL be tied 0.

Verification
REQ-024 Full job, w_base=0, x_base=64, r_base=512, array ready 24 cycles after start -> 64 weight writes, 64 data writes, clear, start, 64 result writes to 512..575, done_o pulse, busy_o 0 afterward.
REQ-025 job_skip_w_i=1 -> zero writes to addresses 0..63; first array write is address 64.
REQ-026 w_base=1020 (MEM_AW=10) -> mem_raddr_o sequence 1020..1023,0..59.
REQ-027 rst_i asserted during RD at j=30 -> outputs zero next edge, job_ro=1; new job completes normally.
REQ-028 SA_SEQ_TIMEOUT_EN, TIMEOUT=255, ready never set -> err_o=1 after 255 WAIT cycles, no res_wr_vo, done_o pulses; err_o clears on next accept.
REQ-029 job_vi held during busy -> exactly one job executed.
